avalon_multi_timer: RTL

AVALON_MULTI_TIMER -- requirements
Module: avalon_multi_timer

---
 rtl/timer_pkg.sv | 23 ++
 rtl/timer_channel.sv | 104 ++++++++++
 rtl/avalon_multi_timer.sv | 58 +++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared register map and field layout for the multi-channel Avalon timer.
package timer_pkg;

  localparam logic [1:0] OFF_STATUS  = 2'd0;
  localparam logic [1:0] OFF_CONTROL = 2'd1;
  localparam logic [1:0] OFF_PERIOD  = 2'd2;
  localparam logic [1:0] OFF_SNAP    = 2'd3;

  localparam int STATUS_TO  = 0;
  localparam int STATUS_RUN = 1;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam int PRESC_LSB = 8;
  localparam int PRESC_W   = 8;

  // Read view of one channel, indexed by register offset.
  typedef logic [3:0][31:0] reg_words_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: prescaler, down-counter with reload, sticky timeout and snapshot.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int RST_PERIOD = 49999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  output reg_words_t  words,
  output logic        irq
);

  localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(RST_PERIOD);

  logic [CNT_W-1:0]   period;
  logic [CNT_W-1:0]   counter;
  logic [CNT_W-1:0]   snap;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] pcnt;
  logic               run;
  logic               to;
  logic               cont;
  logic               ito;
  logic               reload;
  logic               wr_status;
  logic               wr_control;
  logic               wr_period;
  logic               wr_snap;
  logic               start;
  logic               stop;
  logic               tick;
  logic               hit_zero;
  logic               unused_wdata;

  assign wr_status  = wr_en && (offset == OFF_STATUS);
  assign wr_control = wr_en && (offset == OFF_CONTROL);
  assign wr_period  = wr_en && (offset == OFF_PERIOD);
  assign wr_snap    = wr_en && (offset == OFF_SNAP);
  assign start      = wr_control && wdata[CTRL_START];
  assign stop       = wr_control && wdata[CTRL_STOP];

  // A pending reload owns the counter, so no tick may land on that cycle.
  assign tick     = run && !reload && !wr_period && (pcnt == presc);
  assign hit_zero = tick && (counter == CNT_W'(1));

  assign irq          = to && ito;
  assign unused_wdata = ^wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      period  <= RST_CNT;
      counter <= RST_CNT;
      snap    <= '0;
      presc   <= '0;
      pcnt    <= '0;
      run     <= 1'b0;
      to      <= 1'b0;
      cont    <= 1'b0;
      ito     <= 1'b0;
      reload  <= 1'b0;
    end else begin
      reload <= wr_period;
      if (wr_period) period <= wdata[CNT_W-1:0];

      if (reload)      counter <= period;
      else if (tick)   counter <= (counter == '0) ? period : counter - CNT_W'(1);

      if (!run || reload || tick) pcnt <= '0;
      else                        pcnt <= pcnt + PRESC_W'(1);

      if (wr_control) begin
        presc <= wdata[PRESC_LSB +: PRESC_W];
        cont  <= wdata[CTRL_CONT];
        ito   <= wdata[CTRL_ITO];
      end

      // Setting beats clearing so a timeout is never lost to a racing STATUS write.
      if (hit_zero)       to <= 1'b1;
      else if (wr_status) to <= 1'b0;

      if (start)                  run <= 1'b1;
      else if (stop || wr_period) run <= 1'b0;
      else if (hit_zero && !cont) run <= 1'b0;

      if (wr_snap) snap <= counter;
    end
  end

  always_comb begin
    words = '0;
    words[OFF_STATUS][STATUS_TO]               = to;
    words[OFF_STATUS][STATUS_RUN]              = run;
    words[OFF_CONTROL][PRESC_LSB +: PRESC_W]   = presc;
    words[OFF_CONTROL][CTRL_CONT]              = cont;
    words[OFF_CONTROL][CTRL_ITO]               = ito;
    words[OFF_PERIOD]                          = 32'(period);
    words[OFF_SNAP]                            = 32'(snap);
  end

endmodule

// File: rtl/avalon_multi_timer.sv
// Avalon-MM slave wrapping NCH independent timer channels: decode, read mux, irq OR.
module avalon_multi_timer
  import timer_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int CNT_W      = 32,
  parameter int RST_PERIOD = 49999
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(NCH)+1:0]   address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  output logic [NCH-1:0]           irq_vec,
  output logic                     irq
);

  logic        wr;
  logic [29:0] ch_sel;
  logic [31:0] rd_next;
  reg_words_t  words [NCH];

  assign wr     = chipselect && !write_n;
  assign ch_sel = 30'(address >> 2);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    timer_channel #(
      .CNT_W      (CNT_W),
      .RST_PERIOD (RST_PERIOD)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .wr_en  (wr && (ch_sel == 30'(i))),
      .offset (address[1:0]),
      .wdata  (writedata),
      .words  (words[i]),
      .irq    (irq_vec[i])
    );
  end

  assign irq = |irq_vec;

  // Channel numbers beyond NCH match nothing and read back as zero.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_sel == 30'(i)) rd_next = words[i][address[1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_next;
  end

endmodule
